// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the supervisor state encoding and the cycle-counter width helper.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        StPllReset  = 2'd0,
        StWaitLock  = 2'd1,
        StStabilize = 2'd2,
        StRun       = 2'd3
    } sup_state_e;

    // Counter width covering the largest of the three cycle limits, plus one guard bit.
    function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                              input int unsigned stable_cycles,
                                              input int unsigned timeout_cycles);
        int unsigned max_v;
        max_v = rst_cycles;
        if (stable_cycles > max_v) begin
            max_v = stable_cycles;
        end
        if (timeout_cycles > max_v) begin
            max_v = timeout_cycles;
        end
        return $clog2(max_v) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Output is the last flop of the chain; latency is Stages destination edges.
module sync_bit #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for stable lock, releases the
// system reset, retries on lock timeout and restarts on runtime lock loss.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned CNT_W          = 4
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             soft_reset,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             ready,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int unsigned CntW = cnt_width(PLL_RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    sup_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  retry_q, retry_d;
    logic [CNT_W-1:0]  loss_q, loss_d;
    logic              pll_rst_q, sys_reset_q, ready_q;
    logic              locked_s;

    sync_bit #(
        .Stages (SYNC_STAGES)
    ) u_sync_locked (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (soft_reset) begin
            // Restart request outranks every lock event and never touches statistics.
            state_d = StPllReset;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StPllReset: begin
                    if (cnt_q == RstLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (locked_s) begin
                        state_d = StStabilize;
                        cnt_d   = '0;
                    end else if (cnt_q == TimeoutLast) begin
                        state_d = StPllReset;
                        cnt_d   = '0;
                        if (retry_q != '1) begin
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStabilize: begin
                    if (!locked_s) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        state_d = StPllReset;
                        if (loss_q != '1) begin
                            loss_d = loss_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StPllReset;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state itself.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPllReset;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == StPllReset);
            sys_reset_q <= (state_d != StRun);
            ready_q     <= (state_d == StRun);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues expected outputs per edge,
// a monitor pops and compares them at the matching negedge (or immediately on request).
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [3:0] retry_count;
    logic [3:0] lock_loss_count;

    pll_lock_supervisor #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .STABLE_CYCLES  (8),
        .TIMEOUT_CYCLES (32),
        .CNT_W          (4)
    ) dut (
        .refclk          (refclk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .soft_reset      (soft_reset),
        .pll_rst         (pll_rst),
        .sys_reset       (sys_reset),
        .ready           (ready),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         imm;
        string      name;
        logic       pr;
        logic       sr;
        logic       rd;
        logic [3:0] rc;
        logic [3:0] lc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    event chk_now;

    // Negative edge index marks an expectation checked immediately on chk_now.
    task automatic push(input int c, input string nm, input logic pr, input logic sr,
                        input logic rd, input int rc, input int lc);
        exp_t e;
        e.cyc  = c;
        e.imm  = (c < 0);
        e.name = nm;
        e.pr   = pr;
        e.sr   = sr;
        e.rd   = rd;
        e.rc   = 4'(rc);
        e.lc   = 4'(lc);
        q.push_back(e);
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge refclk);
    endtask

    task automatic compare(input exp_t e);
        checks++;
        if (pll_rst !== e.pr || sys_reset !== e.sr || ready !== e.rd ||
            retry_count !== e.rc || lock_loss_count !== e.lc) begin
            failures++;
            $display("FAIL %s cyc=%0d got pll_rst=%b sys_reset=%b ready=%b retry=%0d loss=%0d required pll_rst=%b sys_reset=%b ready=%b retry=%0d loss=%0d",
                     e.name, cyc, pll_rst, sys_reset, ready, retry_count, lock_loss_count,
                     e.pr, e.sr, e.rd, e.rc, e.lc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge refclk or chk_now);
            while (q.size() > 0 && (q[0].imm || q[0].cyc <= cyc)) begin
                e = q.pop_front();
                if (!e.imm && e.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s sample missed: got cyc=%0d required cyc=%0d",
                             e.name, cyc, e.cyc);
                end else begin
                    compare(e);
                end
            end
        end
    end

    initial begin : stimulus
        int b, bb, d, e0, r, s, rk;
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        soft_reset = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        push(-1, "reset_state", 1, 1, 0, 0, 0);
        ->chk_now;

        // Clean lock with pll_locked already high at release.
        wait_cyc(3);
        b = 3;
        push(b + 3,  "t1_pllrst_hi",  1, 1, 0, 0, 0);
        push(b + 4,  "t1_pllrst_lo",  0, 1, 0, 0, 0);
        push(b + 12, "t1_not_ready",  0, 1, 0, 0, 0);
        push(b + 13, "t1_ready",      0, 0, 1, 0, 0);
        rst_n = 1'b1;

        // Lock loss in RUN, then relock.
        bb = b + 20;
        push(bb,      "t4_run",        0, 0, 1, 0, 0);
        push(bb + 2,  "t4_still_run",  0, 0, 1, 0, 0);
        push(bb + 3,  "t4_drop",       1, 1, 0, 0, 1);
        push(bb + 6,  "t4_pulse_end",  1, 1, 0, 0, 1);
        push(bb + 7,  "t4_wait_lock",  0, 1, 0, 0, 1);
        push(bb + 15, "t4_not_ready",  0, 1, 0, 0, 1);
        push(bb + 16, "t4_relock",     0, 0, 1, 0, 1);
        wait_cyc(bb);
        pll_locked = 1'b0;
        wait_cyc(bb + 3);
        pll_locked = 1'b1;

        // soft_reset on the same edge the FSM first sees the dropped lock.
        d = bb + 20;
        push(d + 2, "t5_run",       0, 0, 1, 0, 1);
        push(d + 3, "t5_soft",      1, 1, 0, 0, 1);
        push(d + 4, "t5_no_loss",   1, 1, 0, 0, 1);
        push(d + 6, "t5_pulse_end", 1, 1, 0, 0, 1);
        push(d + 7, "t5_wait_lock", 0, 1, 0, 0, 1);
        wait_cyc(d);
        pll_locked = 1'b0;
        wait_cyc(d + 2);
        soft_reset = 1'b1;
        wait_cyc(d + 3);
        soft_reset = 1'b0;

        // Lock never asserts: retry every 36 edges, count saturates at 15.
        e0 = d + 7;
        for (int k = 1; k <= 17; k++) begin
            rk = e0 + 32 + 36 * (k - 1);
            push(rk - 1, "t2_waiting", 0, 1, 0, sat15(k - 1), 1);
            push(rk,     "t2_retry",   1, 1, 0, sat15(k),     1);
        end
        r = e0 + 32 + 36 * 16;

        // Lock glitch at stabilize count 5 forces a fresh 8-cycle window.
        push(r + 12, "t3_glitch",      0, 1, 0, 15, 1);
        push(r + 13, "t3_no_early",    0, 1, 0, 15, 1);
        push(r + 23, "t3_window_open", 0, 1, 0, 15, 1);
        push(r + 24, "t3_run",         0, 0, 1, 15, 1);
        wait_cyc(r);
        pll_locked = 1'b1;
        wait_cyc(r + 10);
        pll_locked = 1'b0;
        wait_cyc(r + 13);
        pll_locked = 1'b1;

        // Soft restart into STABILIZE, then asynchronous rst_n between edges.
        s = r + 30;
        push(s + 1, "t6_soft",      1, 1, 0, 15, 1);
        push(s + 5, "t6_wait_lock", 0, 1, 0, 15, 1);
        push(s + 9, "t6_stabilize", 0, 1, 0, 15, 1);
        wait_cyc(s);
        soft_reset = 1'b1;
        wait_cyc(s + 1);
        soft_reset = 1'b0;
        wait_cyc(s + 9);
        #2 rst_n = 1'b0;
        #1;
        push(-1, "t6_async_reset", 1, 1, 0, 0, 0);
        ->chk_now;

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge refclk);
        if (q.size() > 0) begin
            checks   += q.size();
            failures += q.size();
            $display("FAIL drain: got %0d unchecked expectations required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits on the far side of the core PLL's rst/locked interface; runs on the PLL reference clock.
- Drives the PLL reset pulse and watches the PLL lock output, which is asynchronous to the supervisor.
- Requires lock to be continuously stable before releasing the system reset.
- Retries the PLL on lock timeout, handles lock loss at runtime, and exposes retry and lock-loss statistics for the OSD/status path.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on pll_locked; must be >=2.
- PLL_RST_CYCLES, 16: pll_rst pulse width in refclk cycles; must be >=1.
- STABLE_CYCLES, 1024: cycles of continuous lock required before release; must be >=1.
- TIMEOUT_CYCLES, 5000000: cycles to wait for lock before retrying the PLL (100 ms at 50 MHz); must be >=1.
- CNT_W, 4: width of the saturating statistic counters.

Ports:
- refclk  in  1  50 MHz reference clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock, asynchronous; synchronized internally (locked_s).
- soft_reset  in  1  refclk-synchronous restart request, single cycle or level.
- pll_rst  out  1  active-high reset to the PLL.
- sys_reset  out  1  active-high reset to the core, held until stable lock.
- ready  out  1  high only while in RUN.
- retry_count  out  CNT_W  saturating count of timeout retries.
- lock_loss_count  out  CNT_W  saturating count of lock losses seen in RUN.

Behaviour:
- Reset (rst_n low, immediate/asynchronous):
  - state=PLL_RESET, counter=0, synchronizer flops=0.
  - pll_rst=1, sys_reset=1, ready=0, retry_count=0, lock_loss_count=0.
  - Asserting rst_n mid-operation in any state forces these values at once.
- Outputs are registered and computed from next-state on the same edge as the state update, so they are glitch-free:
  - pll_rst = (state==PLL_RESET)
  - sys_reset = (state!=RUN)
  - ready = (state==RUN)
- Single down-counter-free cycle counter, width $clog2 of the largest of PLL_RST_CYCLES, STABLE_CYCLES and TIMEOUT_CYCLES, plus 1. It is cleared on every state change.
- States and transitions (evaluated each refclk edge; soft_reset has top priority in every state):
  - soft_reset=1 in any state -> PLL_RESET; no statistic changes.
  - PLL_RESET: counter++. At counter==PLL_RST_CYCLES-1 -> WAIT_LOCK. Occupies exactly PLL_RST_CYCLES edges.
  - WAIT_LOCK:
    - locked_s=1 -> STABILIZE.
    - Otherwise counter++. At counter==TIMEOUT_CYCLES-1 -> PLL_RESET and retry_count++ (saturating at all-ones).
  - STABILIZE:
    - locked_s=0 -> WAIT_LOCK; counter cleared, no retry increment.
    - Otherwise counter++. At counter==STABLE_CYCLES-1 -> RUN. Occupies exactly STABLE_CYCLES edges when lock is clean.
  - RUN:
    - locked_s=0 -> PLL_RESET and lock_loss_count++ (saturating).
    - Otherwise stay.
- Simultaneous events: if soft_reset and lock loss occur together in RUN, enter PLL_RESET and do not increment lock_loss_count.
- Latency:
  - pll_locked rising reaches locked_s after SYNC_STAGES edges.
  - A lock drop in RUN reaches sys_reset=1 within SYNC_STAGES+1 edges.
- Counters never wrap.
- Unused state encodings -> PLL_RESET.

Decomposition:
- Shared package pll_sup_pkg:
  - state enum {PLL_RESET, WAIT_LOCK, STABILIZE, RUN}
  - clog2-based counter width helper
- One sub-module: sync_bit, a parameterized SYNC_STAGES flop chain with async active-low reset. It is reused by other clock-domain inputs.
- The FSM, counter and statistics stay in pll_lock_supervisor.

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, CNT_W=4.
1. Clean lock: release rst_n with pll_locked held at 1 -> pll_rst=1 for exactly 4 edges, then ready=1/sys_reset=0 after edge 13 (4+1+8); both counts stay 0.
2. Lock never asserts: pll_locked=0 -> pll_rst re-pulses every 36 edges; retry_count counts 1,2,… and holds at 15; ready stays 0.
3. Lock glitch in STABILIZE: drop pll_locked for 3 cycles at stabilize counter 5 -> return to WAIT_LOCK; ready rises only after a fresh, uninterrupted 8-cycle window; retry_count unchanged.
4. Lock loss in RUN: deassert pll_locked -> sys_reset=1 and ready=0 within 3 edges; pll_rst pulses 4 edges; lock_loss_count=1; relocks to ready after 13 edges.
5. soft_reset and lock drop reaching locked_s on the same edge in RUN -> PLL_RESET entered; lock_loss_count unchanged.
6. rst_n pulled low mid-STABILIZE (asynchronously, between edges) -> pll_rst=1, sys_reset=1, ready=0 and both counts=0 immediately, without waiting for an edge.
